// File: rtl/instr_exec_unit.sv
// Instruction execution unit: fetches COUNT instructions from the instruction
// register, executes each one and hands its result out over valid/ready.
module instr_exec_unit #(
  parameter int OP_WIDTH   = 32,
  parameter int RES_WIDTH  = 64,
  parameter int ADDR_WIDTH = 5,
  localparam int OPC_WIDTH = 4,
  localparam int INSTR_W   = OPC_WIDTH + 2 * OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] read_pointer,
  input  logic [INSTR_W-1:0]    instruction_word,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic [OPC_WIDTH-1:0]  res_opc,
  output logic [RES_WIDTH-1:0]  result,
  output logic                  res_err,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [OPC_WIDTH-1:0] {
    OPC_ZERO  = 4'd0,
    OPC_PASSA = 4'd1,
    OPC_PASSB = 4'd2,
    OPC_ADD   = 4'd3,
    OPC_SUB   = 4'd4,
    OPC_MULT  = 4'd5,
    OPC_DIV   = 4'd6,
    OPC_MOD   = 4'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT,
    S_FIN
  } state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  state_t                      state;
  logic [ADDR_WIDTH:0]         remaining;
  logic [OPC_WIDTH-1:0]        opc_p0;
  logic signed [OP_WIDTH-1:0]  op_a_p0;
  logic signed [OP_WIDTH-1:0]  op_b_p0;
  logic signed [RES_WIDTH-1:0] exec_res;
  logic                        exec_err;

  // Returns {err, result}; operands are sign-extended before any arithmetic
  // so MULT keeps the full product and DIV/MOD cannot overflow.
  function automatic logic [RES_WIDTH:0] execute(
    input logic [OPC_WIDTH-1:0]       opc,
    input logic signed [OP_WIDTH-1:0] a,
    input logic signed [OP_WIDTH-1:0] b
  );
    logic signed [RES_WIDTH-1:0] ax;
    logic signed [RES_WIDTH-1:0] bx;
    logic signed [RES_WIDTH-1:0] r;
    logic                        err;
    ax  = RES_WIDTH'(a);
    bx  = RES_WIDTH'(b);
    r   = '0;
    err = 1'b0;
    case (opc)
      OPC_ZERO:  r = '0;
      OPC_PASSA: r = ax;
      OPC_PASSB: r = bx;
      OPC_ADD:   r = ax + bx;
      OPC_SUB:   r = ax - bx;
      OPC_MULT:  r = ax * bx;
      OPC_DIV:   if (bx == '0) err = 1'b1; else r = ax / bx;
      OPC_MOD:   if (bx == '0) err = 1'b1; else r = ax % bx;
      default:   err = 1'b1;
    endcase
    return {err, r};
  endfunction

  assign {exec_err, exec_res} = execute(opc_p0, op_a_p0, op_b_p0);

  // Stage p0: instruction captured from the combinational register read.
  always_ff @(posedge clk) begin
    if (state == S_FETCH) begin
      opc_p0  <= instruction_word[INSTR_W-1 -: OPC_WIDTH];
      op_a_p0 <= instruction_word[2*OP_WIDTH-1 -: OP_WIDTH];
      op_b_p0 <= instruction_word[OP_WIDTH-1:0];
    end
  end

  // Stage p1: control FSM and registered result payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      read_pointer <= '0;
      res_valid    <= 1'b0;
      res_addr     <= '0;
      res_opc      <= OPC_ZERO;
      result       <= '0;
      res_err      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (count != '0) begin
              remaining    <= count;
              read_pointer <= first_addr;
              state        <= S_FETCH;
            end else begin
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          result    <= exec_res;
          res_err   <= exec_err;
          res_opc   <= opc_p0;
          res_addr  <= read_pointer;
          res_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid    <= 1'b0;
            remaining    <= remaining - CNT_ONE;
            read_pointer <= read_pointer + PTR_ONE;
            if (remaining == CNT_ONE) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: transaction-queue model plus directed batches.
module tb_instr_exec_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  first_addr;
  logic [5:0]  count;
  logic [4:0]  read_pointer;
  logic [67:0] instruction_word;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_addr;
  logic [3:0]  res_opc;
  logic [63:0] result;
  logic        res_err;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  instr_exec_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_addr         (res_addr),
    .res_opc          (res_opc),
    .result           (result),
    .res_err          (res_err),
    .busy             (busy),
    .done             (done)
  );

  logic [67:0] mem [32];
  assign instruction_word = mem[read_pointer];

  typedef struct {
    logic [4:0] addr;
    logic [3:0] opc;
    longint     res;
    bit         err;
  } txn_t;

  txn_t expq[$];
  txn_t obs[$];
  int   tests_run   = 0;
  int   tests_failed = 0;
  int   done_cnt    = 0;
  bit   mbusy       = 0;
  bit   done_due    = 0;
  bit   stalled     = 0;
  logic [4:0] prev_ptr = '0;

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [67:0] mk(input logic [3:0] opc, input logic [31:0] a,
                                     input logic [31:0] b);
    return {opc, a, b};
  endfunction

  // What one instruction must produce, straight from the arithmetic rules.
  function automatic txn_t model(input logic [4:0] addr, input logic [67:0] w);
    txn_t   t;
    longint a;
    longint b;
    a      = longint'($signed(w[63:32]));
    b      = longint'($signed(w[31:0]));
    t.addr = addr;
    t.opc  = w[67:64];
    t.res  = 0;
    t.err  = 0;
    case (w[67:64])
      4'd0: t.res = 0;
      4'd1: t.res = a;
      4'd2: t.res = b;
      4'd3: t.res = a + b;
      4'd4: t.res = a - b;
      4'd5: t.res = a * b;
      4'd6: if (b == 0) t.err = 1; else t.res = a / b;
      4'd7: if (b == 0) t.err = 1; else t.res = a % b;
      default: t.err = 1;
    endcase
    return t;
  endfunction

  // Compare process: every negative edge, outputs against the model.
  always @(negedge clk) begin
    txn_t       e;
    bit         nb;
    bit         ndue;
    logic [4:0] ad;
    if (!reset_n) begin
      chk("rst_read_pointer", read_pointer, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_addr", res_addr, 0);
      chk("rst_res_opc", res_opc, 0);
      chk("rst_result", $signed(result), 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      expq.delete();
      mbusy    = 0;
      done_due = 0;
      stalled  = 0;
    end else begin
      nb   = mbusy;
      ndue = 0;
      chk("busy", busy, mbusy);
      if (done || done_due) chk("done", done, done_due);
      if (done) begin
        done_cnt++;
        nb = 0;
      end
      if (stalled) chk("stall_read_pointer", read_pointer, prev_ptr);
      if (res_valid) begin
        if (expq.size() == 0) begin
          chk("res_valid_unexpected", res_valid, 0);
        end else begin
          e = expq[0];
          chk("res_addr", res_addr, e.addr);
          chk("res_opc", res_opc, e.opc);
          chk("result", $signed(result), e.res);
          chk("res_err", res_err, e.err);
          if (res_ready) begin
            obs.push_back(e);
            void'(expq.pop_front());
            if (expq.size() == 0) ndue = 1;
          end
        end
      end else if (stalled) begin
        chk("res_valid_dropped", res_valid, 1);
      end
      if (start && !busy) begin
        nb = 1;
        if (count == 0) ndue = 1;
        for (int i = 0; i < int'(count); i++) begin
          ad = 5'(int'(first_addr) + i);
          expq.push_back(model(ad, mem[ad]));
        end
      end
      stalled  = res_valid && !res_ready;
      prev_ptr = read_pointer;
      mbusy    = nb;
      done_due = ndue;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input logic [4:0] fa, input logic [5:0] cnt);
    start      = 1'b1;
    first_addr = fa;
    count      = cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int maxc);
    int n;
    n = 0;
    while (done_cnt < target && n < maxc) begin
      tick();
      n++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
    tick();
  endtask

  task automatic wait_valid_addr(input logic [4:0] a, input int maxc);
    int n;
    n = 0;
    while (!(res_valid && res_addr == a) && n < maxc) begin
      tick();
      n++;
    end
    if (!(res_valid && res_addr == a)) chk("valid_timeout", res_addr, a);
  endtask

  initial begin
    int lat;
    int d0;
    int n;
    start      = 1'b0;
    first_addr = '0;
    count      = '0;
    res_ready  = 1'b1;
    reset_n    = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = mk(4'd0, 32'd0, 32'd0);
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Test 1: ADD/SUB/MULT with latency measured from the start cycle.
    mem[0] = mk(4'd3, 5, 3);
    mem[1] = mk(4'd4, 5, 8);
    mem[2] = mk(4'd5, -7, 6);
    obs.delete();
    d0 = done_cnt;
    start = 1'b1; first_addr = 5'd0; count = 6'd3; lat = 0;
    do begin
      tick();
      start = 1'b0;
      lat++;
    end while (!res_valid && lat < 10);
    chk("t1_latency", lat, 3);
    wait_done(d0 + 1, 50);
    chk("t1_count", obs.size(), 3);
    if (obs.size() >= 3) begin
      chk("t1_res0", obs[0].res, 8);
      chk("t1_res1", obs[1].res, -3);
      chk("t1_res2", obs[2].res, -42);
      chk("t1_addr2", obs[2].addr, 2);
    end

    // Test 2: DIV/MOD signs and divide by zero; start on final handshake ignored.
    mem[4] = mk(4'd6, -15, 4);
    mem[5] = mk(4'd7, -15, 4);
    mem[6] = mk(4'd6, 9, 0);
    obs.delete();
    d0 = done_cnt;
    start_batch(5'd4, 6'd3);
    wait_valid_addr(5'd6, 50);
    start = 1'b1; first_addr = 5'd0; count = 6'd2;
    tick();
    start = 1'b0;
    wait_done(d0 + 1, 50);
    chk("t2_ignored_start_busy", busy, 0);
    chk("t2_count", obs.size(), 3);
    if (obs.size() >= 3) begin
      chk("t2_div", obs[0].res, -3);
      chk("t2_div_err", obs[0].err, 0);
      chk("t2_mod", obs[1].res, -3);
      chk("t2_div0", obs[2].res, 0);
      chk("t2_div0_err", obs[2].err, 1);
    end

    // Test 3: full-width product.
    mem[0] = mk(4'd5, 32'h7FFFFFFF, 32'h7FFFFFFF);
    obs.delete();
    d0 = done_cnt;
    start_batch(5'd0, 6'd1);
    wait_done(d0 + 1, 30);
    chk("t3_count", obs.size(), 1);
    if (obs.size() >= 1) chk("t3_mult", obs[0].res, 64'sh3FFFFFFF00000001);

    // Test 4: pointer wrap plus PASSA/PASSB/ZERO/illegal opcode.
    mem[30] = mk(4'd1, 11, 99);
    mem[31] = mk(4'd2, 99, 22);
    mem[0]  = mk(4'd0, 5, 6);
    mem[1]  = mk(4'hF, 5, 6);
    obs.delete();
    d0 = done_cnt;
    start_batch(5'd30, 6'd4);
    wait_done(d0 + 1, 60);
    chk("t4_count", obs.size(), 4);
    if (obs.size() >= 4) begin
      chk("t4_addr0", obs[0].addr, 30);
      chk("t4_addr2", obs[2].addr, 0);
      chk("t4_addr3", obs[3].addr, 1);
      chk("t4_passa", obs[0].res, 11);
      chk("t4_passb", obs[1].res, 22);
      chk("t4_bad_opc_err", obs[3].err, 1);
    end

    // Test 5: back-pressure for five cycles on the first result.
    mem[10] = mk(4'd3, 1, 2);
    mem[11] = mk(4'd4, 1, 2);
    res_ready = 1'b0;
    obs.delete();
    d0 = done_cnt;
    start_batch(5'd10, 6'd2);
    wait_valid_addr(5'd10, 20);
    for (int i = 0; i < 5; i++) begin
      chk("t5_stall_valid", res_valid, 1);
      chk("t5_stall_ptr", read_pointer, 10);
      chk("t5_stall_result", $signed(result), 3);
      tick();
    end
    res_ready = 1'b1;
    wait_done(d0 + 1, 30);
    chk("t5_count", obs.size(), 2);

    // Full 32-entry batch with irregular ready, starting mid-array.
    for (int i = 0; i < 32; i++) mem[i] = mk(4'(i % 10), 32'(i * 7 - 50), 32'(i - 5));
    obs.delete();
    d0 = done_cnt;
    start_batch(5'd7, 6'd32);
    n = 0;
    while (done_cnt <= d0 && n < 500) begin
      res_ready = (n % 3 != 0);
      tick();
      n++;
    end
    res_ready = 1'b1;
    wait_done(d0 + 1, 10);
    chk("t32_count", obs.size(), 32);
    if (obs.size() >= 32) chk("t32_last_addr", obs[31].addr, 6);

    // Test 6: reset mid-batch, then an empty batch.
    mem[0] = mk(4'd3, 1, 1);
    mem[1] = mk(4'd3, 2, 2);
    mem[2] = mk(4'd3, 3, 3);
    start_batch(5'd0, 6'd3);
    wait_valid_addr(5'd1, 30);
    res_ready = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", res_valid, 0);
    chk("t6_rst_busy", busy, 0);
    tick();
    tick();
    reset_n   = 1'b1;
    res_ready = 1'b1;
    d0 = done_cnt;
    repeat (4) tick();
    chk("t6_no_done", done_cnt, d0);
    start_batch(5'd0, 6'd0);
    chk("t6_empty_done", done, 1);
    chk("t6_empty_valid", res_valid, 0);
    tick();
    chk("t6_empty_done_off", done, 0);
    chk("t6_empty_busy_off", busy, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
